cache_port_arbiter: RTL

- Shares the single read/write port of the on-chip L1 Cache BRAM between the instruction-fetch requester and the data-bus requester (CPU load/store).
- Sits between the riscv64 core and the Cache array, replacing the ad hoc shared address/read-register logic.
- Pipelined: one grant per cycle, 2-cycle fixed read latency, in-order responses.
- Enforces the RAM write window and address checks, and prevents fetch starvation.

---
 rtl/cache_port_arbiter.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/cache_port_arbiter.sv
// ---------------------------------------------------------------------------
// cache_port_arbiter
//
// Shares the single read/write port of the L1 Cache BRAM between the
// instruction-fetch requester and the data-bus (load/store) requester.
// One transfer is accepted per cycle and every response comes back exactly
// two cycles after acceptance, in acceptance order.
//
// Ports
//   clk, reset                  clock and synchronous active-high reset
//   if_req / if_addr            fetch request and byte address
//   if_gnt                      fetch accepted this cycle
//   if_rvalid/if_rdata/if_err   fetch response (1-cycle pulse)
//   d_req/d_we/d_addr/d_wdata   data request, store flag, address, store data
//   d_gnt                       data accepted this cycle
//   d_rvalid/d_rdata/d_err      load data or store completion (1-cycle pulse)
//   mem_addr/mem_we/mem_wdata   registered BRAM word index, write enable, data
//   mem_rdata                   BRAM registered read data (1 cycle after addr)
// ---------------------------------------------------------------------------
module cache_port_arbiter #(
    parameter int          ADDR_W     = 12,
    parameter int          DEPTH      = 3072,
    parameter logic [63:0] RAM_BASE   = 64'h0000_1000,
    parameter logic [63:0] RAM_SIZE   = 64'h0000_0800,
    parameter int          MAX_STARVE = 4
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              if_req,
    input  logic [63:0]       if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,
    output logic              if_err,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [63:0]       d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    output logic              d_err,

    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam logic [63:0] BYTE_LIMIT = 64'(DEPTH) * 64'd4;
    localparam logic [63:0] RAM_END    = RAM_BASE + RAM_SIZE;
    localparam int          SW         = $clog2(MAX_STARVE + 1);
    localparam logic [SW-1:0] STARVE_SAT = SW'(MAX_STARVE);

    // One entry of the response tag pipeline.
    typedef struct packed {
        logic valid;
        logic owner_d;
        logic err;
    } tag_t;

    logic [SW-1:0]     starve_cnt;
    logic              starved;

    logic              acc;
    logic              acc_d;
    logic              acc_we;
    logic [63:0]       acc_addr;
    logic [ADDR_W-1:0] acc_idx;
    logic              acc_err;

    tag_t              tag1;
    tag_t              tag2;

    logic              if_rv;
    logic              d_rv;
    logic [31:0]       resp_data;
    logic [31:0]       if_rdata_q;
    logic [31:0]       d_rdata_q;

    assign starved = (starve_cnt == STARVE_SAT);

    // Data normally wins; once fetch has been denied MAX_STARVE cycles in a
    // row the priority flips for one grant so fetch cannot starve.
    always_comb begin
        if_gnt = 1'b0;
        d_gnt  = 1'b0;
        if (!reset) begin
            if (starved) begin
                if_gnt = if_req;
                d_gnt  = d_req & ~if_req;
            end else begin
                d_gnt  = d_req;
                if_gnt = if_req & ~d_req;
            end
        end
    end

    // Select the accepted transfer and classify it. Stores are only legal
    // inside the RAM window; anything misaligned or past the array errors.
    always_comb begin
        acc_d    = d_req & d_gnt;
        acc      = acc_d | (if_req & if_gnt);
        acc_addr = acc_d ? d_addr : if_addr;
        acc_we   = acc_d & d_we;
        acc_idx  = acc_addr[ADDR_W+1:2];
        acc_err  = (acc_addr[1:0] != 2'b00)
                 || (acc_addr >= BYTE_LIMIT)
                 || (acc_we && ((acc_addr < RAM_BASE) || (acc_addr >= RAM_END)));
    end

    // Count consecutive cycles in which fetch asked but was refused.
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (if_req && !if_gnt) begin
            if (starve_cnt != STARVE_SAT) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end else begin
            starve_cnt <= '0;
        end
    end

    // BRAM command register. Errored transfers never touch the array, so
    // mem_addr keeps its old value and mem_we stays low for them.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
        end else begin
            mem_we <= acc & acc_we & ~acc_err;
            if (acc && !acc_err) begin
                mem_addr <= acc_idx;
            end
            if (acc && acc_we && !acc_err) begin
                mem_wdata <= d_wdata;
            end
        end
    end

    // Two-deep tag shift register lines up with the BRAM read latency so
    // the response owner and error flag arrive together with mem_rdata.
    always_ff @(posedge clk) begin
        if (reset) begin
            tag1 <= '0;
            tag2 <= '0;
        end else begin
            tag1 <= {acc, acc_d, acc_err};
            tag2 <= tag1;
        end
    end

    // Responses are driven straight from the tag and BRAM output; rdata
    // falls back to the last delivered word when no response is present.
    always_comb begin
        if_rv     = ~reset & tag2.valid & ~tag2.owner_d;
        d_rv      = ~reset & tag2.valid & tag2.owner_d;
        resp_data = tag2.err ? 32'h0 : mem_rdata;
        if_rvalid = if_rv;
        d_rvalid  = d_rv;
        if_err    = if_rv & tag2.err;
        d_err     = d_rv & tag2.err;
        if_rdata  = reset ? 32'h0 : (if_rv ? resp_data : if_rdata_q);
        d_rdata   = reset ? 32'h0 : (d_rv ? resp_data : d_rdata_q);
    end

    // Remember the last delivered word for each requester.
    always_ff @(posedge clk) begin
        if (reset) begin
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            if (if_rv) begin
                if_rdata_q <= resp_data;
            end
            if (d_rv) begin
                d_rdata_q <= resp_data;
            end
        end
    end

endmodule
